// File: rtl/toom8_pkg.sv
// Shared constants and FSM state type for the Toom-8 pointwise multiply stage.
package toom8_pkg;

  localparam int N_PTS      = 15;
  localparam int W_OP       = 155;
  localparam int W_PROD     = 2 * W_OP;
  localparam int MUL_LAT    = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int W_IDX      = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/toom8_signed_mul_pipe.sv
// Full-precision signed multiplier with valid/index sideband.
// The consumer's output register is the last of the LAT stages, so only LAT-1 stages live here.
module toom8_signed_mul_pipe #(
  parameter int W_OP   = 155,
  parameter int W_PROD = 310,
  parameter int LAT    = 3,
  parameter int W_IDX  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [W_IDX-1:0]         in_idx,
  input  logic signed [W_OP-1:0]   a,
  input  logic signed [W_OP-1:0]   b,
  output logic                     out_valid,
  output logic [W_IDX-1:0]         out_idx,
  output logic signed [W_PROD-1:0] out_prod
);

  logic signed [W_PROD-1:0] ax;
  logic signed [W_PROD-1:0] bx;
  logic signed [W_PROD-1:0] prod;

  assign ax   = W_PROD'(a);
  assign bx   = W_PROD'(b);
  assign prod = ax * bx;

  generate
    if (LAT <= 1) begin : g_comb
      assign out_valid = in_valid;
      assign out_idx   = in_idx;
      assign out_prod  = prod;
    end else begin : g_pipe
      logic                     vld_q  [LAT-1];
      logic [W_IDX-1:0]         idx_q  [LAT-1];
      logic signed [W_PROD-1:0] prod_q [LAT-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int unsigned s = 0; s < LAT - 1; s++) vld_q[s] <= 1'b0;
        end else begin
          vld_q[0] <= in_valid;
          for (int unsigned s = 1; s < LAT - 1; s++) vld_q[s] <= vld_q[s-1];
        end
      end

      always_ff @(posedge clk) begin
        idx_q[0]  <= in_idx;
        prod_q[0] <= prod;
        for (int unsigned s = 1; s < LAT - 1; s++) begin
          idx_q[s]  <= idx_q[s-1];
          prod_q[s] <= prod_q[s-1];
        end
      end

      assign out_valid = vld_q[LAT-2];
      assign out_idx   = idx_q[LAT-2];
      assign out_prod  = prod_q[LAT-2];
    end
  endgenerate

endmodule

// File: rtl/toom8_pointwise_mul.sv
// Pointwise a_i*b_i over the 15 Toom-8 evaluation points, credit-throttled into an output FIFO.
module toom8_pointwise_mul #(
  parameter int N_PTS      = toom8_pkg::N_PTS,
  parameter int W_OP       = toom8_pkg::W_OP,
  parameter int W_PROD     = toom8_pkg::W_PROD,
  parameter int MUL_LAT    = toom8_pkg::MUL_LAT,
  parameter int FIFO_DEPTH = toom8_pkg::FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_PTS*W_OP-1:0]         a_bus,
  input  logic [N_PTS*W_OP-1:0]         b_bus,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [toom8_pkg::W_IDX-1:0]   out_idx,
  output logic signed [W_PROD-1:0]      out_prod,
  output logic                          out_last
);

  import toom8_pkg::*;

  localparam int W_CNT = $clog2(FIFO_DEPTH + 1);
  localparam int W_PTR = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [W_IDX-1:0] LAST_IDX = W_IDX'(N_PTS - 1);
  localparam logic [W_CNT-1:0] DEPTH_C  = W_CNT'(FIFO_DEPTH);

  state_t                   state;
  logic [W_IDX-1:0]         issue_idx;
  logic [W_CNT-1:0]         credit;
  logic [W_CNT-1:0]         count;
  logic [W_PTR-1:0]         wr_ptr;
  logic [W_PTR-1:0]         rd_ptr;
  logic signed [W_OP-1:0]   a_op [N_PTS];
  logic signed [W_OP-1:0]   b_op [N_PTS];
  logic [W_IDX-1:0]         fifo_idx  [FIFO_DEPTH];
  logic signed [W_PROD-1:0] fifo_prod [FIFO_DEPTH];

  logic                     accept;
  logic                     issue;
  logic                     pop;
  logic                     m_valid;
  logic [W_IDX-1:0]         m_idx;
  logic signed [W_PROD-1:0] m_prod;

  function automatic logic [W_PTR-1:0] ptr_inc(input logic [W_PTR-1:0] p);
    return (p == W_PTR'(FIFO_DEPTH - 1)) ? '0 : p + W_PTR'(1);
  endfunction

  assign accept = in_valid && in_ready;
  assign issue  = (state == ST_ISSUE) && (credit != '0);
  assign pop    = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned i = 0; i < N_PTS; i++) begin
        a_op[i] <= a_bus[W_OP*i +: W_OP];
        b_op[i] <= b_bus[W_OP*i +: W_OP];
      end
    end
  end

  toom8_signed_mul_pipe #(
    .W_OP   (W_OP),
    .W_PROD (W_PROD),
    .LAT    (MUL_LAT),
    .W_IDX  (W_IDX)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (issue),
    .in_idx    (issue_idx),
    .a         (a_op[issue_idx]),
    .b         (b_op[issue_idx]),
    .out_valid (m_valid),
    .out_idx   (m_idx),
    .out_prod  (m_prod)
  );

  // Credits reserve FIFO slots at issue time, so a product leaving the pipe always has room.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      issue_idx <= '0;
      credit    <= DEPTH_C;
    end else begin
      if (issue && !pop)
        credit <= credit - W_CNT'(1);
      else if (pop && !issue)
        credit <= credit + W_CNT'(1);

      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            state     <= ST_ISSUE;
            in_ready  <= 1'b0;
            issue_idx <= '0;
          end
        end
        ST_ISSUE: begin
          if (issue) begin
            if (issue_idx == LAST_IDX)
              state <= ST_DRAIN;
            else
              issue_idx <= issue_idx + W_IDX'(1);
          end
        end
        ST_DRAIN: begin
          if (pop && out_last) begin
            state    <= ST_IDLE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
        fifo_idx[k]  <= '0;
        fifo_prod[k] <= '0;
      end
    end else begin
      if (m_valid) begin
        fifo_idx[wr_ptr]  <= m_idx;
        fifo_prod[wr_ptr] <= m_prod;
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (pop)
        rd_ptr <= ptr_inc(rd_ptr);
      if (m_valid && !pop)
        count <= count + W_CNT'(1);
      else if (pop && !m_valid)
        count <= count - W_CNT'(1);
    end
  end

  assign out_valid = (count != '0);
  assign out_idx   = fifo_idx[rd_ptr];
  assign out_prod  = fifo_prod[rd_ptr];
  assign out_last  = out_valid && (out_idx == LAST_IDX);

endmodule

// File: tb/tb_toom8_pointwise_mul.sv
// Directed bench for toom8_pointwise_mul: known products, ordering, back-pressure and reset.
module tb_toom8_pointwise_mul;

  localparam int NP         = 15;
  localparam int W_OP       = 155;
  localparam int W_PROD     = 310;
  localparam int MUL_LAT    = 3;
  localparam int FIFO_DEPTH = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid;
  logic                     in_ready;
  logic [NP*W_OP-1:0]       a_bus;
  logic [NP*W_OP-1:0]       b_bus;
  logic                     out_valid;
  logic                     out_ready;
  logic [3:0]               out_idx;
  logic signed [W_PROD-1:0] out_prod;
  logic                     out_last;

  int checks = 0;
  int errors = 0;

  logic [3:0]               got_idx  [NP];
  logic signed [W_PROD-1:0] got_prod [NP];
  logic                     got_last [NP];
  int                       got_k    [NP];
  logic signed [W_PROD-1:0] exp_prod [NP];
  int n_got, stab_bad, rdy_seen;

  toom8_pointwise_mul #(
    .N_PTS      (NP),
    .W_OP       (W_OP),
    .W_PROD     (W_PROD),
    .MUL_LAT    (MUL_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_bus     (a_bus),
    .b_bus     (b_bus),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_prod  (out_prod),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic put(input int i, input logic signed [W_OP-1:0] av, input logic signed [W_OP-1:0] bv);
    a_bus[W_OP*i +: W_OP] = av;
    b_bus[W_OP*i +: W_OP] = bv;
  endtask

  // Chunks {8,7,6,5,4,3,2,253} (leading first) evaluated at 0, 1..13 and infinity.
  function automatic longint pev(input int i);
    longint c [8] = '{8, 7, 6, 5, 4, 3, 2, 253};
    longint acc = 0;
    if (i == 14) return 8;
    for (int j = 0; j < 8; j++) acc = acc * i + c[j];
    return acc;
  endfunction

  // Presents the buses; returns at the negedge of the cycle after the accepting edge.
  task automatic send(input bit hold, output bit ok);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    ok = in_ready;
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
  endtask

  // Records popped products; cycle k=1 is the first cycle after the handshake.
  task automatic collect(input bit rand_rdy, input int budget);
    logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [3:0] pi = '0;
    logic signed [W_PROD-1:0] pp = '0;
    n_got = 0; stab_bad = 0; rdy_seen = 0;
    for (int i = 0; i < NP; i++) begin
      got_idx[i] = 4'hf; got_prod[i] = '0; got_last[i] = 1'b0; got_k[i] = -1;
    end
    for (int k = 1; k <= budget && n_got < NP; k++) begin
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (in_ready) rdy_seen++;
      if (pv && !pr && (!out_valid || out_idx !== pi || out_prod !== pp || out_last !== pl))
        stab_bad++;
      if (out_valid && out_ready) begin
        got_idx[n_got]  = out_idx;
        got_prod[n_got] = out_prod;
        got_last[n_got] = out_last;
        got_k[n_got]    = k;
        n_got++;
      end
      pv = out_valid; pr = out_ready; pi = out_idx; pp = out_prod; pl = out_last;
      @(negedge clk);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_bus = '0; b_bus = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: in_ready %0b out_valid %0b out_last %0b want 1 0 0", in_ready, out_valid, out_last);
    end
    checks++;
    if (out_idx !== 4'd0 || out_prod !== '0) begin
      errors++;
      $display("FAIL reset_data: out_idx %0d out_prod %0d want 0 0", out_idx, out_prod);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: in_ready %0b out_valid %0b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_chunks();
    bit ok;
    longint v;
    for (int i = 0; i < NP; i++) begin
      v = pev(i);
      put(i, W_OP'(v), W_OP'(v));
      exp_prod[i] = W_PROD'(v * v);
    end
    out_ready = 1'b1;
    send(1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL chunks_accept: in_ready %0b want 1", in_ready); end
    collect(1'b0, 100);
    checks++;
    if (n_got !== NP) begin errors++; $display("FAIL chunks_count: got %0d want %0d", n_got, NP); end
    for (int i = 0; i < NP; i++) begin
      checks++;
      if (got_idx[i] !== 4'(i) || got_prod[i] !== exp_prod[i] || got_last[i] !== (i == NP - 1)) begin
        errors++;
        $display("FAIL chunks[%0d]: idx %0d prod %0d last %0b want idx %0d prod %0d last %0b",
                 i, got_idx[i], got_prod[i], got_last[i], i, exp_prod[i], (i == NP - 1));
      end
    end
    checks++;
    if (got_prod[0] !== W_PROD'(64009) || got_prod[1] !== W_PROD'(82944) || got_prod[14] !== W_PROD'(64)) begin
      errors++;
      $display("FAIL chunks_known: p0 %0d p1 %0d p14 %0d want 64009 82944 64", got_prod[0], got_prod[1], got_prod[14]);
    end
    checks++;
    if (got_k[0] !== MUL_LAT + 1) begin
      errors++;
      $display("FAIL chunks_latency: first product cycle %0d want %0d", got_k[0], MUL_LAT + 1);
    end
    checks++;
    if (got_k[NP-1] - got_k[0] !== NP - 1) begin
      errors++;
      $display("FAIL chunks_throughput: span %0d want %0d", got_k[NP-1] - got_k[0], NP - 1);
    end
  endtask

  task automatic test_extremes();
    bit ok;
    logic signed [W_OP-1:0]   mn;
    logic signed [W_PROD-1:0] big;
    for (int pass = 0; pass < 2; pass++) begin
      mn  = '0; mn[W_OP-1] = 1'b1;
      big = '0; big[2*W_OP-2] = 1'b1;
      for (int i = 0; i < NP; i++) begin
        if (pass == 0) begin
          put(i, '1, '1);
          exp_prod[i] = W_PROD'(1);
        end else begin
          put(i, mn, mn);
          exp_prod[i] = big;
        end
      end
      send(1'b0, ok);
      collect(1'b0, 100);
      checks++;
      if (!ok || n_got !== NP) begin
        errors++;
        $display("FAIL extreme%0d_count: accept %0b got %0d want 1 %0d", pass, ok, n_got, NP);
      end
      for (int i = 0; i < NP; i++) begin
        checks++;
        if (got_idx[i] !== 4'(i) || got_prod[i] !== exp_prod[i]) begin
          errors++;
          $display("FAIL extreme%0d[%0d]: idx %0d prod %0d want idx %0d prod %0d",
                   pass, i, got_idx[i], got_prod[i], i, exp_prod[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    for (int i = 0; i < NP; i++) begin
      put(i, W_OP'(1000 * i + 1), W_OP'(-3));
      exp_prod[i] = W_PROD'(longint'(-3 * (1000 * i + 1)));
    end
    out_ready = 1'b0;
    send(1'b0, ok);
    repeat (20) @(negedge clk);
    checks++;
    if (dut.count !== 3'd4 || dut.issue_idx !== 4'd4) begin
      errors++;
      $display("FAIL stall_depth: buffered %0d issue_idx %0d want 4 4", dut.count, dut.issue_idx);
    end
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 4'd0 || out_prod !== exp_prod[0]) begin
      errors++;
      $display("FAIL stall_head: valid %0b idx %0d prod %0d want 1 0 %0d", out_valid, out_idx, out_prod, exp_prod[0]);
    end
    collect(1'b0, 100);
    checks++;
    if (!ok || n_got !== NP) begin
      errors++;
      $display("FAIL stall_count: accept %0b got %0d want 1 %0d", ok, n_got, NP);
    end
    for (int i = 0; i < NP; i++) begin
      checks++;
      if (got_idx[i] !== 4'(i) || got_prod[i] !== exp_prod[i] || got_last[i] !== (i == NP - 1)) begin
        errors++;
        $display("FAIL stall[%0d]: idx %0d prod %0d last %0b want idx %0d prod %0d",
                 i, got_idx[i], got_prod[i], got_last[i], i, exp_prod[i]);
      end
    end
  endtask

  task automatic test_random_ready();
    bit ok;
    for (int i = 0; i < NP; i++) begin
      put(i, W_OP'(i + 1), W_OP'(-(i + 2)));
      exp_prod[i] = W_PROD'(longint'(-(i + 1) * (i + 2)));
    end
    send(1'b0, ok);
    collect(1'b1, 400);
    checks++;
    if (!ok || n_got !== NP) begin
      errors++;
      $display("FAIL random_count: accept %0b got %0d want 1 %0d", ok, n_got, NP);
    end
    checks++;
    if (stab_bad !== 0) begin
      errors++;
      $display("FAIL random_stable: unstable stalled cycles %0d want 0", stab_bad);
    end
    for (int i = 0; i < NP; i++) begin
      checks++;
      if (got_idx[i] !== 4'(i) || got_prod[i] !== exp_prod[i] || got_last[i] !== (i == NP - 1)) begin
        errors++;
        $display("FAIL random[%0d]: idx %0d prod %0d last %0b want idx %0d prod %0d",
                 i, got_idx[i], got_prod[i], got_last[i], i, exp_prod[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int t = 0;
    int stray = 0;
    for (int i = 0; i < NP; i++) put(i, W_OP'(77), W_OP'(i));
    out_ready = 1'b1;
    send(1'b0, ok);
    while (dut.issue_idx !== 4'd7 && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (dut.issue_idx !== 4'd7) begin
      errors++;
      $display("FAIL midrst_reach: issue_idx %0d want 7", dut.issue_idx);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_state: out_valid %0b in_ready %0b want 0 1", out_valid, in_ready);
    end
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++;
      $display("FAIL midrst_quiet: cycles with out_valid %0d want 0", stray);
    end
    for (int i = 0; i < NP; i++) begin
      put(i, W_OP'(-(i + 10)), W_OP'(i + 20));
      exp_prod[i] = W_PROD'(longint'(-(i + 10) * (i + 20)));
    end
    send(1'b0, ok);
    collect(1'b0, 100);
    checks++;
    if (!ok || n_got !== NP) begin
      errors++;
      $display("FAIL midrst_count: accept %0b got %0d want 1 %0d", ok, n_got, NP);
    end
    for (int i = 0; i < NP; i++) begin
      checks++;
      if (got_idx[i] !== 4'(i) || got_prod[i] !== exp_prod[i]) begin
        errors++;
        $display("FAIL midrst[%0d]: idx %0d prod %0d want idx %0d prod %0d",
                 i, got_idx[i], got_prod[i], i, exp_prod[i]);
      end
    end
    stray = 0;
    repeat (8) begin
      if (out_valid) stray++;
      @(negedge clk);
    end
    checks++;
    if (stray !== 0) begin
      errors++;
      $display("FAIL midrst_extra: cycles with out_valid %0d want 0", stray);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    for (int i = 0; i < NP; i++) begin
      put(i, W_OP'(i + 1), W_OP'(i + 1));
      exp_prod[i] = W_PROD'(longint'((i + 1) * (i + 1)));
    end
    send(1'b1, ok);
    for (int i = 0; i < NP; i++) put(i, W_OP'(-(i + 5)), W_OP'(2));
    collect(1'b0, 100);
    checks++;
    if (!ok || n_got !== NP || rdy_seen !== 0) begin
      errors++;
      $display("FAIL b2b_first: accept %0b got %0d early_ready %0d want 1 %0d 0", ok, n_got, rdy_seen, NP);
    end
    for (int i = 0; i < NP; i++) begin
      checks++;
      if (got_idx[i] !== 4'(i) || got_prod[i] !== exp_prod[i]) begin
        errors++;
        $display("FAIL b2b_a[%0d]: idx %0d prod %0d want idx %0d prod %0d",
                 i, got_idx[i], got_prod[i], i, exp_prod[i]);
      end
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_reaccept: in_ready %0b want 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < NP; i++) exp_prod[i] = W_PROD'(longint'(-2 * (i + 5)));
    collect(1'b0, 100);
    checks++;
    if (n_got !== NP || got_k[0] !== MUL_LAT + 1) begin
      errors++;
      $display("FAIL b2b_second: got %0d first cycle %0d want %0d %0d", n_got, got_k[0], NP, MUL_LAT + 1);
    end
    for (int i = 0; i < NP; i++) begin
      checks++;
      if (got_idx[i] !== 4'(i) || got_prod[i] !== exp_prod[i] || got_last[i] !== (i == NP - 1)) begin
        errors++;
        $display("FAIL b2b_b[%0d]: idx %0d prod %0d want idx %0d prod %0d",
                 i, got_idx[i], got_prod[i], i, exp_prod[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_chunks();
    test_extremes();
    test_backpressure();
    test_random_ready();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/toom8_pointwise_mul.md
TOOM8_POINTWISE_MUL -- requirements
Module: toom8_pointwise_mul

Interface
REQ-001 SHALL have parameter N_PTS, default 15, meaning number of evaluation points (0, 1..13, inf).
REQ-002 SHALL have parameter W_OP, default 155, meaning signed operand width per point.
REQ-003 SHALL have parameter W_PROD, default 310, meaning signed product width (2*W_OP).
REQ-004 SHALL have parameter MUL_LAT, default 3, meaning multiplier pipeline latency in cycles.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, meaning output buffer entries.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 in_valid  input  1  operand set valid.
REQ-009 in_ready  output  1  block accepts an operand set.
REQ-010 a_bus  input  N_PTS*W_OP  point i at [W_OP*i +: W_OP], signed, sign-extended by producer; i=0 is a0, i=1..13 is a1..a13, i=14 is ainf.
REQ-011 b_bus  input  N_PTS*W_OP  same layout for B.
REQ-012 out_valid  output  1  product available.
REQ-013 out_ready  input  1  consumer (interpolation stage) accepts the product.
REQ-014 out_idx  output  4  point index 0..14 of out_prod.
REQ-015 out_prod  output  W_PROD  signed a_i*b_i.
REQ-016 out_last  output  1  high with out_idx==14.

Function
REQ-017 SHALL capture a_bus/b_bus into operand registers on in_valid&&in_ready; inputs otherwise ignored.
REQ-018 SHALL implement FSM IDLE, ISSUE, DRAIN; in_ready=1 only in IDLE.
REQ-019 IDLE->ISSUE on handshake; issue index resets to 0.
REQ-020 In ISSUE SHALL issue one pair (index i) to the multiplier per cycle when credit>0; otherwise hold i.
REQ-021 Credit counter SHALL init to FIFO_DEPTH, decrement on issue, increment on output pop, unchanged when both occur in one cycle, never exceed FIFO_DEPTH or go below 0.
REQ-022 ISSUE->DRAIN in the cycle index 14 issues; DRAIN->IDLE on out_valid&&out_ready&&out_last.
REQ-023 Products SHALL be full-precision signed, no truncation; enter FIFO exactly MUL_LAT cycles after issue, tagged with index.
REQ-024 Products SHALL leave in index order 0..14; none lost or duplicated under any out_ready pattern.
REQ-025 out_valid = FIFO non-empty; out_idx/out_prod/out_last SHALL hold stable while out_valid&&!out_ready.
REQ-026 With out_ready held 1, first product SHALL appear MUL_LAT+1 cycles after input handshake and last 14 cycles later (throughput 1/cycle).
REQ-027 A new operand set SHALL be accepted no earlier than the cycle after the last product pops.

Reset
REQ-028 On rst: state=IDLE, in_ready=1, out_valid=0, out_last=0, out_idx=0, out_prod=0, credit=FIFO_DEPTH, FIFO empty, multiplier valid pipeline cleared; operand registers need no reset.
REQ-029 rst mid-operation SHALL discard all in-flight and buffered products; no product emitted after rst deasserts until a new handshake.

Structure
REQ-030 Package toom8_pkg SHALL hold N_PTS, W_OP, W_PROD, MUL_LAT, FIFO_DEPTH, index width and the FSM state enum.
REQ-031 Sub-module toom8_signed_mul_pipe SHALL hold the MUL_LAT-stage W_OP x W_OP signed multiplier with valid/index sideband; FIFO and FSM stay in the top.

Verification
REQ-032 Chunks A=B={8,7,6,5,4,3,2,253} evaluated, out_ready=1 -> idx0=64009, idx1=82944 (288^2), idx14=64, out_last only on idx14, 15 products in 15 consecutive cycles.
REQ-033 a_i=-1, b_i=-1 all i -> every product = 1; a_i=-(2^154), b_i=-(2^154) -> every product = 2^308, no overflow.
REQ-034 out_ready=0 for 20 cycles after handshake -> exactly 4 products buffered, issue stalls at idx 4, then out_ready=1 -> remaining 0..14 in order, none lost.
REQ-035 out_ready toggled randomly with a_i=i+1, b_i=-(i+2) -> each out_prod = -(i+1)(i+2), order preserved, outputs stable while stalled.
REQ-036 rst asserted during ISSUE at idx 7 -> out_valid=0 and in_ready=1 next cycle; fresh set then produces correct 15 products only.
REQ-037 in_valid held high through DRAIN -> second set accepted only after first out_last pops; both sets' products correct.
